// File: rtl/alu_uart_ctrl.sv
// Sequencer between a byte-wide UART and a combinational ALU: collects A, B and opcode,
// captures the result, then sends it back as a low byte followed by a zero-extended high byte.
module alu_uart_ctrl #(
    parameter int unsigned NB_DATA     = 8,
    parameter int unsigned NB_OP       = 6,
    parameter int unsigned NB_DATA_OUT = 9
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NB_DATA-1:0]     i_rx_data,
    input  logic                   i_rx_done,
    input  logic                   i_tx_done,
    input  logic [NB_DATA_OUT-1:0] i_alu_result,
    output logic [NB_DATA-1:0]     o_data_a,
    output logic [NB_DATA-1:0]     o_data_b,
    output logic [NB_OP-1:0]       o_code,
    output logic [NB_DATA-1:0]     o_tx_data,
    output logic                   o_tx_start,
    output logic                   o_busy
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        CALC,
        SEND_LO,
        WAIT_LO,
        SEND_HI,
        WAIT_HI
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [NB_DATA-1:0]     r_data_a;
    logic [NB_DATA-1:0]     r_data_b;
    logic [NB_OP-1:0]       r_code;
    logic [NB_DATA_OUT-1:0] r_result;
    logic [NB_DATA-1:0]     r_tx_data;

    logic                   w_load_a;
    logic                   w_load_b;
    logic                   w_load_op;
    logic                   w_load_res;
    logic                   w_load_hi;
    logic                   w_tx_start;
    logic [NB_DATA-1:0]     w_hi_byte;

    // Upper result bits, zero-extended to a full byte.
    assign w_hi_byte = NB_DATA'(r_result >> NB_DATA);

    always_comb begin
        w_state_next = r_state;
        w_load_a     = 1'b0;
        w_load_b     = 1'b0;
        w_load_op    = 1'b0;
        w_load_res   = 1'b0;
        w_load_hi    = 1'b0;
        w_tx_start   = 1'b0;
        unique case (r_state)
            WAIT_A: begin
                if (i_rx_done) begin
                    w_load_a     = 1'b1;
                    w_state_next = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    w_load_b     = 1'b1;
                    w_state_next = WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    w_load_op    = 1'b1;
                    w_state_next = CALC;
                end
            end
            CALC: begin
                w_load_res   = 1'b1;
                w_state_next = SEND_LO;
            end
            SEND_LO: begin
                w_tx_start   = 1'b1;
                w_state_next = WAIT_LO;
            end
            WAIT_LO: begin
                if (i_tx_done) begin
                    w_load_hi    = 1'b1;
                    w_state_next = SEND_HI;
                end
            end
            SEND_HI: begin
                w_tx_start   = 1'b1;
                w_state_next = WAIT_HI;
            end
            WAIT_HI: begin
                if (i_tx_done) begin
                    w_state_next = WAIT_A;
                end
            end
            default: w_state_next = WAIT_A;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= WAIT_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The low byte is loaded alongside the result so it is already valid in SEND_LO.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data_a  <= '0;
            r_data_b  <= '0;
            r_code    <= '0;
            r_result  <= '0;
            r_tx_data <= '0;
        end else begin
            if (w_load_a) begin
                r_data_a <= i_rx_data;
            end
            if (w_load_b) begin
                r_data_b <= i_rx_data;
            end
            if (w_load_op) begin
                r_code <= i_rx_data[NB_OP-1:0];
            end
            if (w_load_res) begin
                r_result  <= i_alu_result;
                r_tx_data <= i_alu_result[NB_DATA-1:0];
            end
            if (w_load_hi) begin
                r_tx_data <= w_hi_byte;
            end
        end
    end

    assign o_data_a   = r_data_a;
    assign o_data_b   = r_data_b;
    assign o_code     = r_code;
    assign o_tx_data  = r_tx_data;
    assign o_tx_start = w_tx_start;
    assign o_busy     = (r_state != WAIT_A);

endmodule
